// File: rtl/daq3_spi_responder.sv
// 3-wire SPI target modelling the DAQ3 converter/clock-chip register interface.
// All SPI pins are oversampled into clk; the register file is served over shared SDIO.
module daq3_spi_responder #(
  parameter int         NUM_REGS  = 16,
  parameter logic [7:0] CHIP_ID   = 8'h44,
  parameter logic [7:0] RESET_VAL = 8'h00
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        spi_csn,
  input  logic        spi_clk,
  input  logic        spi_sdio_i,
  output logic        spi_sdio_o,
  output logic        spi_sdio_t,
  output logic        wr_stb,
  output logic [14:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        busy
);

  localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_INSTR, S_DATA_WR, S_DATA_RD} state_t;

  logic r_csn_s1, r_csn_s2, r_csn_d;
  logic r_sclk_s1, r_sclk_s2, r_sclk_d;
  logic r_sdio_s1, r_sdio_s2;
  logic [1:0] r_flush;
  logic r_armed;

  state_t      r_state;
  logic [3:0]  r_bit_cnt;
  logic [14:0] r_shift;
  logic [14:0] r_addr;
  logic [7:0]  r_out_shift;
  logic        r_load_pend;
  logic [7:0]  r_regs [NUM_REGS];

  logic        w_cs_fall, w_cs_rise, w_sclk_rise, w_sclk_fall;
  logic [15:0] w_instr;
  logic [7:0]  w_byte;
  logic        w_in_range, w_commit;
  logic [7:0]  w_rd_val;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_csn_s1  <= 1'b1;
      r_csn_s2  <= 1'b1;
      r_csn_d   <= 1'b1;
      r_sclk_s1 <= 1'b0;
      r_sclk_s2 <= 1'b0;
      r_sclk_d  <= 1'b0;
      r_sdio_s1 <= 1'b0;
      r_sdio_s2 <= 1'b0;
    end else begin
      r_csn_s1  <= spi_csn;
      r_csn_s2  <= r_csn_s1;
      r_csn_d   <= r_csn_s2;
      r_sclk_s1 <= spi_clk;
      r_sclk_s2 <= r_sclk_s1;
      r_sclk_d  <= r_sclk_s2;
      r_sdio_s1 <= spi_sdio_i;
      r_sdio_s2 <= r_sdio_s1;
    end
  end

  // A CS-low level present at reset release must not look like a falling edge:
  // only arm once the synchroniser has flushed and CS has been seen high.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_flush <= 2'd0;
      r_armed <= 1'b0;
    end else begin
      if (r_flush != 2'd3) r_flush <= r_flush + 2'd1;
      if (r_flush == 2'd3 && r_csn_s2) r_armed <= 1'b1;
    end
  end

  assign w_cs_fall   = r_csn_d & ~r_csn_s2 & r_armed;
  assign w_cs_rise   = ~r_csn_d & r_csn_s2;
  assign w_sclk_rise = r_sclk_s2 & ~r_sclk_d;
  assign w_sclk_fall = ~r_sclk_s2 & r_sclk_d;
  assign w_instr     = {r_shift, r_sdio_s2};
  assign w_byte      = w_instr[7:0];
  assign w_in_range  = (r_addr < 15'(NUM_REGS));
  assign w_commit    = (r_state == S_DATA_WR) && w_sclk_rise && !w_cs_rise &&
                       (r_bit_cnt == 4'd7) && w_in_range && (r_addr != 15'd1);
  assign busy        = ~r_csn_s2;

  always_comb begin
    w_rd_val = 8'h00;
    if (r_addr == 15'd1)  w_rd_val = CHIP_ID;
    else if (w_in_range)  w_rd_val = r_regs[r_addr[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= RESET_VAL;
    end else if (w_commit) begin
      r_regs[r_addr[AW-1:0]] <= w_byte;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_bit_cnt   <= 4'd0;
      r_shift     <= 15'd0;
      r_addr      <= 15'd0;
      r_out_shift <= 8'd0;
      r_load_pend <= 1'b0;
      spi_sdio_o  <= 1'b0;
      spi_sdio_t  <= 1'b1;
      wr_stb      <= 1'b0;
      wr_addr     <= 15'd0;
      wr_data     <= 8'd0;
    end else begin
      wr_stb <= 1'b0;
      if (w_cs_rise) begin
        r_state    <= S_IDLE;
        spi_sdio_t <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE: if (w_cs_fall) begin
            r_state   <= S_INSTR;
            r_bit_cnt <= 4'd0;
            r_shift   <= 15'd0;
          end
          S_INSTR: if (w_sclk_rise) begin
            r_shift   <= w_instr[14:0];
            r_bit_cnt <= r_bit_cnt + 4'd1;
            if (r_bit_cnt == 4'd15) begin
              r_addr    <= w_instr[14:0];
              r_bit_cnt <= 4'd0;
              if (w_instr[15]) begin
                r_state     <= S_DATA_RD;
                r_load_pend <= 1'b1;
              end else begin
                r_state <= S_DATA_WR;
              end
            end
          end
          S_DATA_WR: if (w_sclk_rise) begin
            r_shift   <= w_instr[14:0];
            r_bit_cnt <= r_bit_cnt + 4'd1;
            if (r_bit_cnt == 4'd7) begin
              wr_stb    <= 1'b1;
              wr_addr   <= r_addr;
              wr_data   <= w_byte;
              r_addr    <= r_addr + 15'd1;
              r_bit_cnt <= 4'd0;
            end
          end
          S_DATA_RD: begin
            if (w_sclk_rise) begin
              r_bit_cnt <= r_bit_cnt + 4'd1;
              if (r_bit_cnt == 4'd7) begin
                r_addr      <= r_addr + 15'd1;
                r_bit_cnt   <= 4'd0;
                r_load_pend <= 1'b1;
              end
            end else if (w_sclk_fall) begin
              if (r_load_pend) begin
                spi_sdio_o  <= w_rd_val[7];
                r_out_shift <= {w_rd_val[6:0], 1'b0};
                spi_sdio_t  <= 1'b0;
                r_load_pend <= 1'b0;
              end else begin
                spi_sdio_o  <= r_out_shift[7];
                r_out_shift <= {r_out_shift[6:0], 1'b0};
              end
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_daq3_spi_responder.sv
// Directed bench for daq3_spi_responder: bit-banged SPI master at SCLK = clk/10.
// Inputs are driven and outputs sampled on the clk falling edge.
module tb_daq3_spi_responder;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        spi_csn = 1'b1;
  logic        spi_clk = 1'b0;
  logic        spi_sdio_i = 1'b0;
  logic        spi_sdio_o, spi_sdio_t, wr_stb, busy;
  logic [14:0] wr_addr;
  logic [7:0]  wr_data;

  daq3_spi_responder #(.NUM_REGS(16), .CHIP_ID(8'h44), .RESET_VAL(8'h00)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .spi_csn    (spi_csn),
    .spi_clk    (spi_clk),
    .spi_sdio_i (spi_sdio_i),
    .spi_sdio_o (spi_sdio_o),
    .spi_sdio_t (spi_sdio_t),
    .wr_stb     (wr_stb),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail = 0;
  int          stb_cnt = 0;
  int          n_drive = 0;
  logic [14:0] stb_addr [16];
  logic [7:0]  stb_data [16];
  int          t_instr_low, t_data_low;
  logic        busy_mid, t_before_cs, t_after_cs;

  always @(negedge clk) begin
    if (wr_stb) begin
      if (stb_cnt < 16) begin
        stb_addr[stb_cnt] <= wr_addr;
        stb_data[stb_cnt] <= wr_data;
      end
      stb_cnt <= stb_cnt + 1;
    end
    if (!spi_sdio_t) n_drive <= n_drive + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_bit(input logic b, output logic r, output logic t);
    spi_sdio_i = b;
    tick(5);
    r = spi_sdio_o;
    t = spi_sdio_t;
    spi_clk = 1'b1;
    tick(5);
    spi_clk = 1'b0;
  endtask

  // Data bits are taken MSB-first from wdata[31]; read bits shift into rdata LSB.
  task automatic spi_xfer(input logic rw, input logic [14:0] addr, input int nbits,
                          input logic [31:0] wdata, input int rst_bit,
                          output logic [31:0] rdata);
    logic [15:0] instr;
    logic r, t;
    instr = {rw, addr};
    rdata = 32'd0;
    t_instr_low = 0;
    t_data_low = 0;
    spi_csn = 1'b0;
    tick(5);
    for (int i = 0; i < 16; i++) begin
      if (i == rst_bit) begin
        resetn = 1'b0;
        tick(2);
        resetn = 1'b1;
      end
      spi_bit(instr[15-i], r, t);
      if (!t) t_instr_low++;
    end
    busy_mid = busy;
    for (int i = 0; i < nbits; i++) begin
      spi_bit(wdata[31-i], r, t);
      rdata = {rdata[30:0], r};
      if (!t) t_data_low++;
    end
    tick(5);
    t_before_cs = spi_sdio_t;
    spi_csn = 1'b1;
    tick(4);
    t_after_cs = spi_sdio_t;
    tick(8);
    $display("xfer %s addr=0x%04h bits=%0d wdata=0x%08h rdata=0x%0h", rw ? "RD" : "WR",
             addr, nbits, wdata, rdata);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int nd0;
    tick(5);
    resetn = 1'b1;
    tick(10);
    check_val("rst_sdio_t", spi_sdio_t, 1);
    check_val("rst_sdio_o", spi_sdio_o, 0);
    check_val("rst_wr_stb", wr_stb, 0);
    check_val("rst_wr_addr", wr_addr, 0);
    check_val("rst_wr_data", wr_data, 0);
    check_val("rst_busy", busy, 0);

    spi_xfer(1'b0, 15'h0003, 8, 32'hA500_0000, -1, rd);
    check_val("wr3_stb_cnt", stb_cnt, 1);
    check_val("wr3_addr", stb_addr[0], 15'h0003);
    check_val("wr3_data", stb_data[0], 8'hA5);
    check_val("wr3_busy_mid", busy_mid, 1);
    check_val("wr3_never_drive", t_data_low, 0);
    check_val("wr3_busy_after", busy, 0);

    spi_xfer(1'b1, 15'h0003, 8, 32'h0, -1, rd);
    check_val("rd3_data", rd[7:0], 8'hA5);
    check_val("rd3_t_instr", t_instr_low, 0);
    check_val("rd3_t_data", t_data_low, 8);
    check_val("rd3_t_after", t_after_cs, 1);

    spi_xfer(1'b1, 15'h0001, 8, 32'h0, -1, rd);
    check_val("rd1_chip_id", rd[7:0], 8'h44);
    spi_xfer(1'b1, 15'h0005, 8, 32'h0, -1, rd);
    check_val("rd5_zero", rd[7:0], 8'h00);
    spi_xfer(1'b0, 15'h0001, 8, 32'h7700_0000, -1, rd);
    check_val("wr1_stb_cnt", stb_cnt, 2);
    check_val("wr1_addr", stb_addr[1], 15'h0001);
    check_val("wr1_data", stb_data[1], 8'h77);
    spi_xfer(1'b1, 15'h0001, 8, 32'h0, -1, rd);
    check_val("rd1_after_wr", rd[7:0], 8'h44);

    spi_xfer(1'b0, 15'h000E, 24, 32'h1122_3300, -1, rd);
    check_val("strm_stb_cnt", stb_cnt, 5);
    check_val("strm_addr0", stb_addr[2], 15'h000E);
    check_val("strm_addr1", stb_addr[3], 15'h000F);
    check_val("strm_addr2", stb_addr[4], 15'h0010);
    check_val("strm_data0", stb_data[2], 8'h11);
    check_val("strm_data1", stb_data[3], 8'h22);
    check_val("strm_data2", stb_data[4], 8'h33);
    spi_xfer(1'b1, 15'h000E, 24, 32'h0, -1, rd);
    check_val("strm_rd", rd[23:0], 24'h112200);

    spi_xfer(1'b0, 15'h0002, 5, 32'hFF00_0000, -1, rd);
    check_val("part_wr_no_stb", stb_cnt, 5);
    spi_xfer(1'b1, 15'h0002, 8, 32'h0, -1, rd);
    check_val("part_wr_rd2", rd[7:0], 8'h00);
    spi_xfer(1'b1, 15'h0001, 3, 32'h0, -1, rd);
    check_val("part_rd_bits", rd[2:0], 3'b010);
    check_val("part_rd_t_before", t_before_cs, 0);
    check_val("part_rd_t_after", t_after_cs, 1);

    nd0 = n_drive;
    spi_xfer(1'b1, 15'h0001, 8, 32'h0, 10, rd);
    check_val("rstmid_no_drive", n_drive - nd0, 0);
    check_val("rstmid_no_stb", stb_cnt, 5);
    spi_xfer(1'b1, 15'h0003, 8, 32'h0, -1, rd);
    check_val("rstmid_rd3_reset", rd[7:0], 8'h00);
    spi_xfer(1'b1, 15'h0001, 8, 32'h0, -1, rd);
    check_val("rstmid_rd1", rd[7:0], 8'h44);

    for (int i = 0; i < 20; i++) begin
      spi_clk = ~spi_clk;
      spi_sdio_i = ~spi_sdio_i;
      tick(3);
    end
    spi_sdio_i = 1'b0;
    check_val("idle_sclk_t", spi_sdio_t, 1);
    spi_xfer(1'b1, 15'h0001, 8, 32'h0, -1, rd);
    check_val("idle_sclk_rd1", rd[7:0], 8'h44);
    check_val("idle_sclk_no_stb", stb_cnt, 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
